// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: transform-size limits, reorder FSM
// states and the N3/N5 legality check used by the transpose and reorder memories.
package fft_pkg;

   localparam int MAX_N3    = 27;
   localparam int MAX_N5    = 25;
   localparam int MEM_DEPTH = MAX_N3 * MAX_N5;
   localparam int ADDR_W    = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN
   } state_t;

   function automatic logic cfg_legal(input logic [7:0] p3, input logic [4:0] p5,
                                      input int max3, input int max5);
      return (p3 != 8'd0) && (int'(p3) <= max3) && (p5 != 5'd0) && (int'(p5) <= max5);
   endfunction

endpackage

// File: rtl/reorder_addr_gen.sv
// Write-address generator: walks column-major input beats and produces the
// natural-order bin k = c5*N3 + c3 incrementally, without a multiplier.
module reorder_addr_gen #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic [7:0]    n3,
   input  logic [4:0]    n5,
   output logic [AW-1:0] wr_addr,
   output logic          wr_last
);

   logic [7:0]    c3_q;
   logic [4:0]    c5_q;
   logic [AW-1:0] k_q;
   logic          c5_wrap;

   assign c5_wrap = (c5_q == n5 - 5'd1);
   assign wr_last = c5_wrap && (c3_q == n3 - 8'd1);
   assign wr_addr = k_q;

   // Inner c5 steps k by N3; a c5 wrap restarts k at the next column c3+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c3_q <= 8'd0;
         c5_q <= 5'd0;
         k_q  <= '0;
      end else if (adv) begin
         if (wr_last) begin
            c3_q <= 8'd0;
            c5_q <= 5'd0;
            k_q  <= '0;
         end else if (c5_wrap) begin
            c3_q <= c3_q + 8'd1;
            c5_q <= 5'd0;
            k_q  <= AW'(c3_q) + AW'(1);
         end else begin
            c5_q <= c5_q + 5'd1;
            k_q  <= k_q + AW'(n3);
         end
      end
   end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: collects one column-major symbol, then streams it
// out in natural bin order over a valid/ready handshake.
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int MAX_N3 = 27,
   parameter int MAX_N5 = 25
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              pow3,
   input  logic [4:0]              pow5,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic                    out_last,
   output logic                    busy,
   output logic                    cfg_err
);

   localparam int DEPTH = MAX_N3 * MAX_N5;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t                  state_q, state_d;
   logic                    first_q;
   logic [7:0]              n3_q, cur_n3;
   logic [4:0]              n5_q, cur_n5;
   logic [AW-1:0]           rd_q, n_q, wr_addr;
   logic                    wr_last, legal, acc, wr_en, rd_load, out_fire;
   logic signed [WIDTH-1:0] mem_re [DEPTH];
   logic signed [WIDTH-1:0] mem_im [DEPTH];

   assign in_ready = (state_q == FILL);
   assign busy     = (state_q != IDLE);
   assign legal    = cfg_legal(pow3, pow5, MAX_N3, MAX_N5);
   assign acc      = in_valid && in_ready;
   assign wr_en    = acc && (!first_q || legal);
   // The first beat of a symbol runs on the live pow3/pow5; later beats use the latched copy.
   assign cur_n3   = first_q ? pow3 : n3_q;
   assign cur_n5   = first_q ? pow5 : n5_q;
   assign rd_load  = (state_q == DRAIN) && (!out_valid || out_ready) && (rd_q < n_q);
   assign out_fire = (state_q == DRAIN) && out_valid && out_ready && out_last;

   reorder_addr_gen #(
      .AW(AW)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .adv     (wr_en),
      .n3      (cur_n3),
      .n5      (cur_n5),
      .wr_addr (wr_addr),
      .wr_last (wr_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FILL;
         FILL:    if (wr_en && wr_last) state_d = DRAIN;
         DRAIN:   if (out_fire) state_d = FILL;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_addr] <= in_re;
         mem_im[wr_addr] <= in_im;
      end
   end

   // Control and output register; n_q counts written beats so the read side needs no N3*N5 product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q   <= 1'b1;
         n3_q      <= 8'd0;
         n5_q      <= 5'd0;
         n_q       <= '0;
         rd_q      <= '0;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
      end else begin
         cfg_err <= acc && first_q && !legal;
         if (wr_en) begin
            n_q     <= n_q + ADDR_ONE;
            first_q <= 1'b0;
            if (first_q) begin
               n3_q <= pow3;
               n5_q <= pow5;
            end
         end
         if (rd_load) begin
            out_valid <= 1'b1;
            out_re    <= mem_re[rd_q];
            out_im    <= mem_im[rd_q];
            out_last  <= (rd_q == n_q - ADDR_ONE);
            rd_q      <= rd_q + ADDR_ONE;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (out_fire) begin
            first_q <= 1'b1;
            n_q     <= '0;
            rd_q    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: natural-order reordering, stalls,
// illegal configuration, mid-symbol reset and the single-point symbol.
module tb_fft_out_reorder;

   localparam int WIDTH = 18;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [7:0]              pow3 = 8'd0;
   logic [4:0]              pow5 = 5'd0;
   logic                    in_valid = 1'b0;
   logic                    out_ready = 1'b0;
   logic signed [WIDTH-1:0] in_re = '0;
   logic signed [WIDTH-1:0] in_im = '0;
   logic                    in_ready, out_valid, out_last, busy, cfg_err;
   logic signed [WIDTH-1:0] out_re, out_im;

   int errors = 0;
   int checks = 0;

   logic signed [WIDTH-1:0] got_re   [675];
   logic signed [WIDTH-1:0] got_im   [675];
   logic                    got_last [675];
   int exp35 [15] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14};

   always #5 clk = ~clk;

   fft_out_reorder #(
      .WIDTH  (WIDTH),
      .MAX_N3 (27),
      .MAX_N5 (25)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pow3      (pow3),
      .pow5      (pow5),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_last  (out_last),
      .busy      (busy),
      .cfg_err   (cfg_err)
   );

   // Drives n beats (value base+m on re, its negation on im); called #1 after a clock edge.
   task automatic feed(input int p3, input int p5, input int n, input int base, output bit ok);
      int   m = 0;
      int   guard = 0;
      logic rdy;
      pow3 = 8'(p3);
      pow5 = 5'(p5);
      while (m < n && guard < 2000) begin
         in_valid = 1'b1;
         in_re    = WIDTH'(base + m);
         in_im    = WIDTH'(-(base + m));
         rdy      = in_ready;
         @(posedge clk); #1;
         guard++;
         if (rdy) m++;
      end
      in_valid = 1'b0;
      ok = (m == n);
   endtask

   // Records accepted output beats; notes any change while stalled and any in_ready during drain.
   task automatic collect(input int n, input bit random_ready, output int cnt,
                          output bit stable_ok, output bit rdy_low);
      int                 guard = 0;
      bit                 held = 1'b0;
      logic [2*WIDTH:0]   hv = '0;
      cnt = 0;
      stable_ok = 1'b1;
      rdy_low = 1'b1;
      while (cnt < n && guard < 5000) begin
         out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (held && (!out_valid || {out_re, out_im, out_last} !== hv)) stable_ok = 1'b0;
         held = 1'b0;
         if (out_valid) begin
            if (in_ready) rdy_low = 1'b0;
            if (out_ready) begin
               got_re[cnt]   = out_re;
               got_im[cnt]   = out_im;
               got_last[cnt] = out_last;
               cnt++;
            end else begin
               held = 1'b1;
               hv   = {out_re, out_im, out_last};
            end
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_re !== '0 || out_im !== '0) begin errors++; $display("FAIL reset_out_data: got %0d/%0d want 0/0", out_re, out_im); end
      checks++; if (out_last !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_flags: last=%b busy=%b cfg_err=%b want 0", out_last, busy, cfg_err); end
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_cycle: busy=%b in_ready=%b want 0/0", busy, in_ready); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL enter_fill: busy=%b in_ready=%b want 1/1", busy, in_ready); end
   endtask

   task automatic test_3x5(input int base, input string tag);
      bit ok, st, rl;
      int cnt;
      feed(3, 5, 15, base, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s_feed: beats not accepted in time", tag); end
      collect(15, 1'b0, cnt, st, rl);
      checks++; if (cnt != 15) begin errors++; $display("FAIL %s_count: got %0d want 15", tag, cnt); end
      for (int k = 0; k < cnt; k++) begin
         checks++;
         if (got_re[k] !== WIDTH'(base + exp35[k]) || got_im[k] !== WIDTH'(-(base + exp35[k])) || got_last[k] !== (k == 14)) begin
            errors++;
            $display("FAIL %s_bin%0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b", tag, k,
                     got_re[k], got_im[k], got_last[k], base + exp35[k], -(base + exp35[k]), (k == 14));
         end
      end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL %s_back_to_fill: in_ready=%b out_valid=%b want 1/0", tag, in_ready, out_valid); end
   endtask

   task automatic test_full();
      bit ok, st, rl;
      int cnt, bad, v;
      feed(27, 25, 675, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_feed: beats not accepted in time"); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_after_last: got %b want 0", in_ready); end
      collect(675, 1'b0, cnt, st, rl);
      checks++; if (cnt != 675) begin errors++; $display("FAIL full_count: got %0d want 675", cnt); end
      checks++; if (!rl) begin errors++; $display("FAIL full_in_ready_drain: in_ready seen high during drain, want low"); end
      bad = 0;
      for (int k = 0; k < cnt; k++) begin
         v = (k % 27) * 25 + k / 27;
         if (got_re[k] !== WIDTH'(v) || got_last[k] !== (k == 674)) begin
            if (bad < 5) $display("FAIL full_bin%0d: got re=%0d last=%b want re=%0d last=%b", k, got_re[k], got_last[k], v, (k == 674));
            bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL full_bins: %0d bad bins, want 0", bad); end
   endtask

   task automatic test_stall();
      bit ok, st, rl;
      int cnt, bad, v;
      feed(9, 5, 45, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_feed: beats not accepted in time"); end
      collect(45, 1'b1, cnt, st, rl);
      checks++; if (cnt != 45) begin errors++; $display("FAIL stall_count: got %0d want 45", cnt); end
      checks++; if (!st) begin errors++; $display("FAIL stall_stable: output changed while stalled, want held"); end
      bad = 0;
      for (int k = 0; k < cnt; k++) begin
         v = 300 + (k % 9) * 5 + k / 9;
         if (got_re[k] !== WIDTH'(v) || got_im[k] !== WIDTH'(-v) || got_last[k] !== (k == 44)) begin
            if (bad < 5) $display("FAIL stall_bin%0d: got re=%0d last=%b want re=%0d last=%b", k, got_re[k], got_last[k], v, (k == 44));
            bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_bins: %0d bad bins, want 0", bad); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_cfg_err();
      bit ok, st, rl;
      int cnt;
      pow3 = 8'd3; pow5 = 5'd0; in_valid = 1'b1; in_re = WIDTH'(77); in_im = WIDTH'(77);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
      @(posedge clk); #1;
      checks++; if (cfg_err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL cfg_err_one_cycle: cfg_err=%b in_ready=%b want 0/1", cfg_err, in_ready); end
      feed(3, 1, 3, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cfg3x1_feed: beats not accepted in time"); end
      collect(3, 1'b0, cnt, st, rl);
      checks++; if (cnt != 3) begin errors++; $display("FAIL cfg3x1_count: got %0d want 3", cnt); end
      for (int k = 0; k < cnt; k++) begin
         checks++;
         if (got_re[k] !== WIDTH'(100 + k) || got_last[k] !== (k == 2)) begin
            errors++;
            $display("FAIL cfg3x1_bin%0d: got re=%0d last=%b want re=%0d last=%b", k, got_re[k], got_last[k], 100 + k, (k == 2));
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      feed(3, 5, 7, 50, ok);
      checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL mid_partial: ok=%b busy=%b want 1/1", ok, busy); end
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: in_ready=%b out_valid=%b busy=%b want 0", in_ready, out_valid, busy); end
      checks++; if (out_re !== '0 || out_im !== '0 || out_last !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL mid_reset_data: re=%0d im=%0d last=%b cfg_err=%b want 0", out_re, out_im, out_last, cfg_err); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_3x5(200, "after_reset");
   endtask

   task automatic test_n1();
      bit ok;
      feed(1, 1, 1, 'h155, ok);
      checks++; if (!ok || out_valid !== 1'b0) begin errors++; $display("FAIL n1_latency1: ok=%b out_valid=%b want 1/0", ok, out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_re !== WIDTH'('h155) || out_im !== WIDTH'(-'h155) || out_last !== 1'b1) begin
         errors++;
         $display("FAIL n1_output: valid=%b re=%0h last=%b want 1/155/1", out_valid, out_re, out_last);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL n1_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
   endtask

   initial begin
      test_reset();
      test_3x5(0, "sym3x5");
      test_full();
      test_stall();
      test_cfg_err();
      test_reset_mid();
      test_n1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
